// File: rtl/dec8b10b_pkg.sv
// Shared types and constants for the 8B/10B receive-side sequencer.
// Comma prefixes are the seven bits a..f,i (in_sym[9:3]) of K28.1/K28.5/K28.7.
package dec8b10b_pkg;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } sync_state_t;

  localparam logic [6:0] COMMA_N    = 7'b0011111;
  localparam logic [6:0] COMMA_P    = 7'b1100000;
  localparam logic [7:0] K28_5_BYTE = 8'hBC;

endpackage

// File: rtl/dec8b10b_comma_det.sv
// Combinational comma detector on the abcdeif prefix of a raw code group.
// Kept separate so the upstream bit aligner can reuse it.
module dec8b10b_comma_det
  import dec8b10b_pkg::*;
(
  input  logic [6:0] sym_hi,
  output logic       comma_n,
  output logic       comma_p
);

  assign comma_n = (sym_hi == COMMA_N);
  assign comma_p = (sym_hi == COMMA_P);

endmodule

// File: rtl/dec8b10b_sync_ctrl.sv
// Receive sequencer around the combinational 8B/10B decoder: running disparity,
// word-sync acquire/lose FSM with bit-slip requests, output qualification, error count.
module dec8b10b_sync_ctrl
  import dec8b10b_pkg::*;
#(
  parameter int COMMAS_TO_LOCK  = 3,
  parameter int ERR_TO_LOSE     = 4,
  parameter int GOOD_TO_RECOVER = 4,
  parameter int SLIP_WAIT       = 20,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [9:0]       in_sym,
  input  logic [7:0]       dec_data,
  input  logic             dec_k,
  input  logic             dec_code_err,
  input  logic             dec_rd_err,
  input  logic             dec_rd_out,
  output logic             rd_to_dec,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_k,
  output logic             out_err,
  output logic             sync_ok,
  output logic             bitslip,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_cnt,
  output sync_state_t      dbg_state
);

  localparam logic [3:0] LOCK_N    = 4'(COMMAS_TO_LOCK);
  localparam logic [3:0] LOSE_N    = 4'(ERR_TO_LOSE);
  localparam logic [3:0] GOOD_N    = 4'(GOOD_TO_RECOVER);
  localparam logic [7:0] SLIP_LAST = 8'(SLIP_WAIT - 1);

  sync_state_t state, state_next;
  logic [3:0]  comma_cnt, comma_cnt_next;
  logic [3:0]  err_cnt, err_cnt_next;
  logic [3:0]  good_cnt, good_cnt_next;
  logic [7:0]  slip_cnt, slip_cnt_next;
  logic        slip_fire;
  logic        err_inc;
  logic        rd_reg;
  logic        comma_n, comma_p, comma;
  logic        sym_ok;
  logic        unused_sym_lsbs;

  dec8b10b_comma_det u_comma_det (
    .sym_hi  (in_sym[9:3]),
    .comma_n (comma_n),
    .comma_p (comma_p)
  );

  assign unused_sym_lsbs = ^in_sym[2:0];
  assign comma           = comma_n | comma_p;
  assign sym_ok          = ~dec_code_err & ~dec_rd_err;
  assign dbg_state       = state;

  // A comma fixes its own disparity, so re-seed the decoder from it.
  assign rd_to_dec = comma_n ? 1'b0 : (comma_p ? 1'b1 : rd_reg);

  always_comb begin
    state_next     = state;
    comma_cnt_next = comma_cnt;
    err_cnt_next   = err_cnt;
    good_cnt_next  = good_cnt;
    slip_cnt_next  = slip_cnt;
    slip_fire      = 1'b0;
    err_inc        = 1'b0;
    if (in_valid) begin
      case (state)
        LOS: begin
          if (comma && sym_ok) begin
            comma_cnt_next = 4'd1;
            slip_cnt_next  = '0;
            if (LOCK_N == 4'd1) begin
              state_next    = SYNC;
              err_cnt_next  = '0;
              good_cnt_next = '0;
            end else begin
              state_next = ACQ;
            end
          end else if (comma) begin
            slip_cnt_next = '0;
          end else if (slip_cnt == SLIP_LAST) begin
            slip_fire     = 1'b1;
            slip_cnt_next = '0;
          end else begin
            slip_cnt_next = slip_cnt + 8'd1;
          end
        end
        ACQ: begin
          if (!sym_ok) begin
            state_next     = LOS;
            comma_cnt_next = '0;
            slip_cnt_next  = '0;
          end else if (comma) begin
            if (comma_cnt + 4'd1 == LOCK_N) begin
              state_next    = SYNC;
              err_cnt_next  = '0;
              good_cnt_next = '0;
            end else begin
              comma_cnt_next = comma_cnt + 4'd1;
            end
          end
        end
        SYNC: begin
          if (!sym_ok) begin
            err_inc       = 1'b1;
            good_cnt_next = '0;
            if (err_cnt + 4'd1 == LOSE_N) begin
              state_next     = LOS;
              err_cnt_next   = '0;
              comma_cnt_next = '0;
              slip_cnt_next  = '0;
            end else begin
              err_cnt_next = err_cnt + 4'd1;
            end
          end else if (err_cnt != 4'd0) begin
            // A run of good symbols forgives one accumulated error.
            if (good_cnt + 4'd1 == GOOD_N) begin
              err_cnt_next  = err_cnt - 4'd1;
              good_cnt_next = '0;
            end else begin
              good_cnt_next = good_cnt + 4'd1;
            end
          end
        end
        default: state_next = LOS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOS;
      comma_cnt <= '0;
      err_cnt   <= '0;
      good_cnt  <= '0;
      slip_cnt  <= '0;
    end else begin
      state     <= state_next;
      comma_cnt <= comma_cnt_next;
      err_cnt   <= err_cnt_next;
      good_cnt  <= good_cnt_next;
      slip_cnt  <= slip_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reg    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_k     <= 1'b0;
      out_err   <= 1'b0;
      sync_ok   <= 1'b0;
      bitslip   <= 1'b0;
      err_count <= '0;
    end else begin
      sync_ok <= (state_next == SYNC);
      bitslip <= slip_fire;
      if (in_valid) begin
        rd_reg    <= dec_rd_out;
        out_data  <= dec_data;
        out_k     <= dec_k;
        out_err   <= ~sym_ok;
        out_valid <= (state == SYNC) & sym_ok;
      end else begin
        out_valid <= 1'b0;
        out_err   <= 1'b0;
      end
      if (clr_cnt) begin
        err_count <= '0;
      end else if (err_inc && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dec8b10b_sync_ctrl.sv
// Self-checking bench for dec8b10b_sync_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the link-sync rules.
module tb_dec8b10b_sync_ctrl;
  import dec8b10b_pkg::*;

  localparam int COMMAS_TO_LOCK  = 3;
  localparam int ERR_TO_LOSE     = 4;
  localparam int GOOD_TO_RECOVER = 4;
  localparam int SLIP_WAIT       = 20;
  localparam int CNT_W           = 16;

  localparam logic [9:0] K28_5_N = 10'b0011111010;
  localparam logic [9:0] K28_5_P = 10'b1100000101;
  localparam logic [9:0] D21_5   = 10'b1010101010;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [9:0]       in_sym;
  logic [7:0]       dec_data;
  logic             dec_k;
  logic             dec_code_err;
  logic             dec_rd_err;
  logic             dec_rd_out;
  logic             rd_to_dec;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_k;
  logic             out_err;
  logic             sync_ok;
  logic             bitslip;
  logic [CNT_W-1:0] err_count;
  logic             clr_cnt;
  sync_state_t      dbg_state;

  dec8b10b_sync_ctrl #(
    .COMMAS_TO_LOCK  (COMMAS_TO_LOCK),
    .ERR_TO_LOSE     (ERR_TO_LOSE),
    .GOOD_TO_RECOVER (GOOD_TO_RECOVER),
    .SLIP_WAIT       (SLIP_WAIT),
    .CNT_W           (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_sym       (in_sym),
    .dec_data     (dec_data),
    .dec_k        (dec_k),
    .dec_code_err (dec_code_err),
    .dec_rd_err   (dec_rd_err),
    .dec_rd_out   (dec_rd_out),
    .rd_to_dec    (rd_to_dec),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_k        (out_k),
    .out_err      (out_err),
    .sync_ok      (sync_ok),
    .bitslip      (bitslip),
    .err_count    (err_count),
    .clr_cnt      (clr_cnt),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = hunting, 1 = acquiring, 2 = locked.
  int         m_mode, m_commas, m_errs, m_goods, m_since_comma, m_err_count;
  logic       m_rd;
  logic       e_valid, e_err, e_k, e_sync, e_slip, e_rd_to_dec;
  logic [7:0] e_data;
  logic       obs_rd_to_dec;

  function automatic void model_reset();
    m_mode = 0; m_commas = 0; m_errs = 0; m_goods = 0; m_since_comma = 0;
    m_err_count = 0; m_rd = 1'b0;
    e_valid = 0; e_err = 0; e_k = 0; e_data = '0; e_sync = 0; e_slip = 0;
  endfunction

  function automatic void model_update(input logic v, input logic [9:0] sym, input logic [7:0] data,
                                       input logic k, input logic ce, input logic re, input logic clr);
    bit ok, is_comma, err_hit;
    ok       = !ce && !re;
    is_comma = (sym[9:3] == COMMA_N) || (sym[9:3] == COMMA_P);
    err_hit  = 0;
    e_slip   = 0;
    if (!v) begin
      e_valid = 0; e_err = 0;
    end else begin
      e_data = data; e_k = k; e_err = !ok; e_valid = (m_mode == 2) && ok;
      if (m_mode == 0) begin
        if (is_comma && ok) begin
          m_since_comma = 0; m_commas = 1; m_errs = 0; m_goods = 0;
          m_mode = (COMMAS_TO_LOCK == 1) ? 2 : 1;
        end else if (is_comma) begin
          m_since_comma = 0;
        end else begin
          m_since_comma++;
          if (m_since_comma == SLIP_WAIT) begin e_slip = 1; m_since_comma = 0; end
        end
      end else if (m_mode == 1) begin
        if (!ok) begin
          m_mode = 0; m_commas = 0; m_since_comma = 0;
        end else if (is_comma) begin
          m_commas++;
          if (m_commas == COMMAS_TO_LOCK) begin m_mode = 2; m_errs = 0; m_goods = 0; end
        end
      end else begin
        if (!ok) begin
          err_hit = 1; m_goods = 0; m_errs++;
          if (m_errs == ERR_TO_LOSE) begin m_mode = 0; m_errs = 0; m_commas = 0; m_since_comma = 0; end
        end else if (m_errs > 0) begin
          m_goods++;
          if (m_goods == GOOD_TO_RECOVER) begin m_errs--; m_goods = 0; end
        end
      end
    end
    if (clr) m_err_count = 0;
    else if (err_hit && m_err_count < 65535) m_err_count++;
    e_sync = (m_mode == 2);
  endfunction

  function automatic logic [9:0] rand_nc();
    logic [9:0] s;
    do s = 10'($urandom); while (s[9:3] == COMMA_N || s[9:3] == COMMA_P);
    return s;
  endfunction

  // One symbol slot: drive at negedge, capture rd_to_dec, advance model, settle after posedge.
  task automatic drive(input logic v, input logic [9:0] sym, input logic [7:0] data, input logic k,
                       input logic ce, input logic re, input logic rdo, input logic clr);
    @(negedge clk);
    in_valid = v; in_sym = sym; dec_data = data; dec_k = k;
    dec_code_err = ce; dec_rd_err = re; dec_rd_out = rdo; clr_cnt = clr;
    #1;
    obs_rd_to_dec = rd_to_dec;
    e_rd_to_dec   = (sym[9:3] == COMMA_N) ? 1'b0 : ((sym[9:3] == COMMA_P) ? 1'b1 : m_rd);
    model_update(v, sym, data, k, ce, re, clr);
    if (v) m_rd = rdo;
    @(posedge clk);
    #1;
  endtask

  task automatic send_comma();   drive(1, K28_5_N, K28_5_BYTE, 1, 0, 0, 1, 0); endtask
  task automatic send_comma_p(); drive(1, K28_5_P, K28_5_BYTE, 1, 0, 0, 0, 0); endtask
  task automatic send_d215();    drive(1, D21_5, 8'hB5, 0, 0, 0, m_rd, 0); endtask
  task automatic send_good();    drive(1, rand_nc(), 8'($urandom), 0, 0, 0, 1'($urandom), 0); endtask
  task automatic send_bad(input logic clr);
    drive(1, rand_nc(), 8'($urandom), 0, 1, 1'($urandom), 1'($urandom), clr);
  endtask
  task automatic send_idle();    drive(0, rand_nc(), 8'($urandom), 1'($urandom), 0, 0, 0, 0); endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 0; in_sym = '0; dec_data = '0; dec_k = 0;
    dec_code_err = 0; dec_rd_err = 0; dec_rd_out = 0; clr_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic lock_link();
    apply_reset();
    repeat (COMMAS_TO_LOCK) send_comma();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if ({out_valid, out_data, out_k, out_err, sync_ok, bitslip, err_count} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_data, out_k, out_err, sync_ok, bitslip, err_count}); end
    checks++; if (rd_to_dec !== 1'b0) begin
      failures++; $display("FAIL reset_rd got=%0b exp=0", rd_to_dec); end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      send_comma();
      checks++; if (obs_rd_to_dec !== 1'b0) begin
        failures++; $display("FAIL lock_rd_comma_n got=%0b exp=0", obs_rd_to_dec); end
      checks++; if (sync_ok !== (i == 2)) begin
        failures++; $display("FAIL lock_sync i=%0d got=%0b exp=%0b", i, sync_ok, (i == 2)); end
      checks++; if (out_valid !== 1'b0) begin
        failures++; $display("FAIL lock_valid_comma i=%0d got=%0b exp=0", i, out_valid); end
      send_d215();
      checks++; if (out_valid !== (i == 2)) begin
        failures++; $display("FAIL lock_valid_data i=%0d got=%0b exp=%0b", i, out_valid, (i == 2)); end
    end
    checks++; if (out_data !== 8'hB5 || out_k !== 1'b0) begin
      failures++; $display("FAIL lock_data got=%h/%0b exp=b5/0", out_data, out_k); end
  endtask

  task automatic test_recover();
    lock_link();
    send_bad(0);
    checks++; if (out_err !== 1'b1 || err_count !== 16'd1 || sync_ok !== 1'b1) begin
      failures++; $display("FAIL recover_err got=%0b/%0d/%0b exp=1/1/1", out_err, err_count, sync_ok); end
    for (int i = 0; i < GOOD_TO_RECOVER; i++) begin
      send_good();
      checks++; if (out_err !== 1'b0 || out_valid !== 1'b1 || sync_ok !== 1'b1) begin
        failures++; $display("FAIL recover_good i=%0d got=%0b/%0b/%0b exp=0/1/1", i, out_err, out_valid, sync_ok); end
    end
    // With the error forgiven, three more still leave the link up.
    repeat (ERR_TO_LOSE - 1) send_bad(0);
    checks++; if (sync_ok !== 1'b1 || err_count !== 16'd4) begin
      failures++; $display("FAIL recover_margin got=%0b/%0d exp=1/4", sync_ok, err_count); end
  endtask

  task automatic test_lose();
    lock_link();
    for (int e = 0; e < ERR_TO_LOSE; e++) begin
      send_bad(0);
      checks++; if (sync_ok !== (e < ERR_TO_LOSE - 1)) begin
        failures++; $display("FAIL lose_sync e=%0d got=%0b exp=%0b", e, sync_ok, (e < ERR_TO_LOSE - 1)); end
      if (e < ERR_TO_LOSE - 1) repeat (3) send_good();
    end
    repeat (2) begin
      send_d215();
      checks++; if (out_valid !== 1'b0) begin
        failures++; $display("FAIL lose_valid got=%0b exp=0", out_valid); end
    end
    checks++; if (err_count !== 16'd4) begin
      failures++; $display("FAIL lose_count got=%0d exp=4", err_count); end
  endtask

  task automatic test_bitslip();
    int pulses;
    pulses = 0;
    apply_reset();
    for (int i = 1; i <= 2 * SLIP_WAIT; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_idle();
        checks++; if (bitslip !== 1'b0) begin
          failures++; $display("FAIL slip_idle i=%0d got=%0b exp=0", i, bitslip); end
      end
      if ($urandom_range(0, 3) == 0) send_bad(0); else send_good();
      if (bitslip === 1'b1) pulses++;
      checks++; if (bitslip !== (i % SLIP_WAIT == 0)) begin
        failures++; $display("FAIL slip_pulse i=%0d got=%0b exp=%0b", i, bitslip, (i % SLIP_WAIT == 0)); end
    end
    checks++; if (pulses !== 2) begin
      failures++; $display("FAIL slip_total got=%0d exp=2", pulses); end
  endtask

  task automatic test_acq_abort();
    apply_reset();
    repeat (2) send_comma();
    send_bad(0);
    checks++; if (sync_ok !== 1'b0 || err_count !== 16'd0) begin
      failures++; $display("FAIL acq_abort got=%0b/%0d exp=0/0", sync_ok, err_count); end
    for (int i = 0; i < 3; i++) begin
      send_comma();
      checks++; if (sync_ok !== (i == 2)) begin
        failures++; $display("FAIL acq_relock i=%0d got=%0b exp=%0b", i, sync_ok, (i == 2)); end
    end
  endtask

  task automatic test_comma_p_clr();
    apply_reset();
    send_comma_p();
    checks++; if (obs_rd_to_dec !== 1'b1) begin
      failures++; $display("FAIL comma_p_rd got=%0b exp=1", obs_rd_to_dec); end
    send_comma();
    checks++; if (obs_rd_to_dec !== 1'b0) begin
      failures++; $display("FAIL comma_n_rd got=%0b exp=0", obs_rd_to_dec); end
    send_d215();
    checks++; if (obs_rd_to_dec !== 1'b1) begin
      failures++; $display("FAIL held_rd got=%0b exp=1", obs_rd_to_dec); end
    send_comma();
    send_bad(1);
    checks++; if (err_count !== 16'd0 || out_err !== 1'b1) begin
      failures++; $display("FAIL clr_priority got=%0d/%0b exp=0/1", err_count, out_err); end
    send_bad(0);
    checks++; if (err_count !== 16'd1) begin
      failures++; $display("FAIL clr_after got=%0d exp=1", err_count); end
  endtask

  task automatic test_mid_reset();
    lock_link();
    send_bad(0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({out_valid, out_k, out_err, sync_ok, bitslip, err_count, out_data} !== '0) begin
      failures++; $display("FAIL mid_reset got=%h exp=0", {out_valid, out_k, out_err, sync_ok, bitslip, err_count, out_data}); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        if ($urandom_range(0, 1) == 1)
          drive(1, K28_5_N, K28_5_BYTE, 1, ($urandom_range(0, 9) == 0), 0, 1, ($urandom_range(0, 49) == 0));
        else
          drive(1, K28_5_P, K28_5_BYTE, 1, 0, ($urandom_range(0, 9) == 0), 0, ($urandom_range(0, 49) == 0));
      end else if (r < 80) begin
        drive(1, rand_nc(), 8'($urandom), 1'($urandom), 0, 0, 1'($urandom), ($urandom_range(0, 49) == 0));
      end else if (r < 90) begin
        send_bad($urandom_range(0, 49) == 0);
      end else begin
        send_idle();
      end
      checks++; if (obs_rd_to_dec !== e_rd_to_dec) begin
        failures++; $display("FAIL rnd_rd n=%0d got=%0b exp=%0b", n, obs_rd_to_dec, e_rd_to_dec); end
      checks++; if (out_valid !== e_valid) begin
        failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, out_valid, e_valid); end
      checks++; if (out_data !== e_data || out_k !== e_k) begin
        failures++; $display("FAIL rnd_data n=%0d got=%h/%0b exp=%h/%0b", n, out_data, out_k, e_data, e_k); end
      checks++; if (out_err !== e_err) begin
        failures++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, out_err, e_err); end
      checks++; if (sync_ok !== e_sync) begin
        failures++; $display("FAIL rnd_sync n=%0d got=%0b exp=%0b", n, sync_ok, e_sync); end
      checks++; if (bitslip !== e_slip) begin
        failures++; $display("FAIL rnd_slip n=%0d got=%0b exp=%0b", n, bitslip, e_slip); end
      checks++; if (err_count !== CNT_W'(m_err_count)) begin
        failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, err_count, m_err_count); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_recover();
    test_lose();
    test_bitslip();
    test_acq_abort();
    test_comma_p_clr();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec8b10b_sync_ctrl.md
Name: dec8b10b_sync_ctrl

Overview:
- Receive-side sequencer for the combinational 8B/10B decoder (6b/5b, 4b/3b, disparity and invalid-code logic).
- Owns the running-disparity register that feeds the decoder's rd input. Detects commas on the raw code group and runs a word-sync acquire/lose state machine with bit-slip requests.
- Qualifies decoded bytes for downstream logic and keeps an error counter.

Parameters:
COMMAS_TO_LOCK, 3, consecutive-ish commas (no intervening invalid) needed in ACQ to enter SYNC; range 1..15
ERR_TO_LOSE, 4, accumulated invalid symbols in SYNC that force LOS; range 1..15
GOOD_TO_RECOVER, 4, consecutive valid symbols that cancel one accumulated error; range 1..15
SLIP_WAIT, 20, valid-input symbols without a comma in LOS before a bitslip pulse; range 2..255
CNT_W, 16, width of error counter

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
in_valid  in  1  in_sym is a new code group this cycle
in_sym  in  10  raw code group, [9]=a,[8]=b,[7]=c,[6]=d,[5]=e,[4]=i,[3]=f,[2]=g,[1]=h,[0]=j
dec_data  in  8  decoder output HGFEDCBA for in_sym
dec_k  in  1  decoder control-character flag
dec_code_err  in  1  decoder invalid-code flag
dec_rd_err  in  1  decoder disparity-error flag
dec_rd_out  in  1  decoder running disparity after in_sym (1=positive)
rd_to_dec  out  1  running disparity driven to decoder rd input (combinational)
out_valid  out  1  registered: decoded byte valid and link in SYNC
out_data  out  8  registered decoded byte
out_k  out  1  registered control flag
out_err  out  1  registered: symbol invalid (with in_valid, any state)
sync_ok  out  1  registered: state==SYNC
bitslip  out  1  one-cycle request to upstream aligner to shift one bit
err_count  out  CNT_W  saturating count of invalid symbols seen in SYNC
clr_cnt  in  1  synchronous clear of err_count

Behaviour:
- Reset (async, active-high) sets all registered outputs to 0. It also sets rd_reg=0 (negative), state=LOS, and all internal counters to 0. Reset asserted mid-operation aborts immediately.
- Comma: in_sym[9:3]==7'b0011111 (comma_n) or 7'b1100000 (comma_p).
- rd_to_dec: comma_n gives 0, comma_p gives 1, otherwise rd_reg. This re-seeds disparity so a correct comma never reports rd_err.
- Symbol valid: sym_ok = ~dec_code_err & ~dec_rd_err. Nothing below advances when in_valid=0.
- rd_reg update on in_valid: rd_reg<=dec_rd_out, including on error, so the decoder resumes from its computed disparity.
- Datapath latency is 1 cycle. On in_valid:
  - out_data<=dec_data, out_k<=dec_k, out_err<=~sym_ok.
  - out_valid<=(state==SYNC, pre-update) & sym_ok.
- Datapath when in_valid=0: out_valid and out_err go to 0; out_data and out_k hold.
- LOS:
  - comma & sym_ok: comma_cnt<=1, go to ACQ (LOS if COMMAS_TO_LOCK==1 goes straight to SYNC).
  - Otherwise slip_cnt++. When slip_cnt reaches SLIP_WAIT-1, bitslip=1 for that cycle and slip_cnt<=0.
  - slip_cnt clears on any comma.
- ACQ:
  - ~sym_ok: go to LOS, clear counters.
  - comma & sym_ok: comma_cnt++. When it reaches COMMAS_TO_LOCK, go to SYNC with err_cnt=0, good_cnt=0.
  - Valid non-comma: stay.
- SYNC, ~sym_ok:
  - err_count saturating +1.
  - good_cnt<=0.
  - If err_cnt+1==ERR_TO_LOSE, go to LOS, otherwise err_cnt++.
- SYNC, sym_ok with err_cnt>0:
  - good_cnt++.
  - When good_cnt+1==GOOD_TO_RECOVER, err_cnt--, good_cnt<=0.
- SYNC, sym_ok with err_cnt==0: good_cnt stays 0.
- sync_ok is registered from the next state, so it rises in the cycle after the locking comma is accepted.
- clr_cnt takes priority over a simultaneous increment; err_count then reads 0.
- bitslip is never asserted outside LOS and is never asserted on consecutive cycles.

Decomposition:
- Shared package dec8b10b_pkg holds:
  - state enum {LOS, ACQ, SYNC};
  - constants COMMA_N=7'b0011111 and COMMA_P=7'b1100000;
  - K28_5_BYTE=8'hBC.
- One natural sub-module, dec8b10b_comma_det: combinational comma_n/comma_p from in_sym[9:3], reusable by the aligner.
- FSM, counters and the rd register stay in this module.

Test Plan:
- Reset, then 3× K28.5 RD- (0011111010) interleaved with D21.5 -> sync_ok=1 one cycle after 3rd comma; out_valid=0 before, 1 with out_data=8'hB5 after.
- In SYNC inject 1 code error then 4 valid -> err_cnt 1→0, sync_ok stays 1, err_count=1, out_err pulses once.
- In SYNC inject 4 invalid with 3 valid between each -> sync_ok drops after 4th error; subsequent out_valid=0.
- LOS with 20 non-comma symbols -> bitslip single pulse on 20th; 40 symbols -> exactly 2 pulses.
- ACQ after 2 commas then invalid symbol -> return to LOS, no sync_ok; next 3 commas lock.
- comma_p (1100000101) while rd_reg=0 -> rd_to_dec=1, no rd_err; clr_cnt with simultaneous error -> err_count=0.
